// File: rtl/jk_cmd_sequencer_if.sv
// rtl/jk_cmd_sequencer_if.sv - command handshake and JK flop-bank signal bundle
//
// Ports (signals):
//   CMD_VALID/CMD_READY     command handshake
//   CMD_OP/MASK/REPEAT      command payload: {J,K} code, bit mask, repeat count
//   J, K                    drive to the flop bank
//   Q_IN                    Q fed back from the flop bank
//   EXPECTED, BUSY, MISMATCH  sequencer status
// master: command source and flop bank side; slave: the sequencer.
interface jk_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [1:0]       CMD_OP;
    logic [WIDTH-1:0] CMD_MASK;
    logic [CNT_W-1:0] CMD_REPEAT;
    logic [WIDTH-1:0] J;
    logic [WIDTH-1:0] K;
    logic [WIDTH-1:0] Q_IN;
    logic [WIDTH-1:0] EXPECTED;
    logic             BUSY;
    logic             MISMATCH;

    modport master (
        output CMD_VALID, CMD_OP, CMD_MASK, CMD_REPEAT, Q_IN,
        input  CMD_READY, J, K, EXPECTED, BUSY, MISMATCH
    );

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_MASK, CMD_REPEAT, Q_IN,
        output CMD_READY, J, K, EXPECTED, BUSY, MISMATCH
    );
endinterface

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - FIFO-fed JK command sequencer with flop-bank model and Q check
//
// Ports:
//   CLK    rising-edge clock
//   RESET  synchronous active-high reset (shared with the downstream flop bank)
//   bus    jk_cmd_sequencer_if.slave: command handshake, J/K drive, Q feedback, status
module jk_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    jk_cmd_sequencer_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mis_q, mis_d;

    logic [1:0]       op_mem   [DEPTH];
    logic [WIDTH-1:0] mask_mem [DEPTH];
    logic [CNT_W-1:0] rep_mem  [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full, empty, push, pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.CMD_VALID && !full;

    assign bus.CMD_READY = !full;
    assign bus.J         = j_q;
    assign bus.K         = k_q;
    assign bus.EXPECTED  = exp_q;
    assign bus.MISMATCH  = mis_q;
    assign bus.BUSY      = (state_q != IDLE) || !empty;

    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        mis_d   = mis_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // empty reflects pointers before this edge, so a command
                // pushed now is not visible until the next edge.
                if (!empty) begin
                    pop     = 1'b1;
                    j_d     = mask_mem[rd_ptr[AW-1:0]] & {WIDTH{op_mem[rd_ptr[AW-1:0]][1]}};
                    k_d     = mask_mem[rd_ptr[AW-1:0]] & {WIDTH{op_mem[rd_ptr[AW-1:0]][0]}};
                    cnt_d   = rep_mem[rd_ptr[AW-1:0]];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Same update the flop bank performs on this edge.
                exp_d = (j_q & ~exp_q) | (~k_q & exp_q);
                if (cnt_q == '0) begin
                    j_d     = '0;
                    k_d     = '0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK: begin
                if (bus.Q_IN != exp_q) begin
                    mis_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            j_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            mis_q   <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            mis_q   <= mis_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && push) begin
            op_mem[wr_ptr[AW-1:0]]   <= bus.CMD_OP;
            mask_mem[wr_ptr[AW-1:0]] <= bus.CMD_MASK;
            rep_mem[wr_ptr[AW-1:0]]  <= bus.CMD_REPEAT;
        end
    end
endmodule

// File: doc/jk_cmd_sequencer.md
Name: jk_cmd_sequencer

Overview:
Command sequencer that sits directly upstream of a bank of WIDTH jkff flip-flops and drives their J/K inputs. It accepts set/clear/toggle/hold commands through a valid/ready handshake into a small FIFO. Each command is applied to a masked subset of flops for a programmable number of cycles. It keeps a reference model of the flop bank and checks the fed-back Q outputs after every command.

Parameters:
WIDTH, 4, number of JK flip-flops driven (J/K/Q_IN width)
DEPTH, 4, command FIFO entries; power of 2, at least 2
CNT_W, 4, width of the repeat-count field

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous reset, active high; also drives the downstream jkff bank's RESET
CMD_VALID  input  1  command present
CMD_READY  output  1  FIFO can accept; equals !full
CMD_OP  input  2  {J,K} code: 00 hold, 01 clear, 10 set, 11 toggle
CMD_MASK  input  WIDTH  1 = bit affected; 0 = bit gets J=K=0
CMD_REPEAT  input  CNT_W  apply op for CMD_REPEAT+1 consecutive cycles
J  output  WIDTH  registered J to the flop bank
K  output  WIDTH  registered K to the flop bank
Q_IN  input  WIDTH  Q outputs fed back from the flop bank
EXPECTED  output  WIDTH  model of the flop bank state
BUSY  output  1  high when state is not IDLE or FIFO is non-empty
MISMATCH  output  1  sticky error flag

Behaviour:
- Reset (RESET high at an edge):
  - FIFO emptied; state IDLE; counter 0.
  - J=K=0, EXPECTED=0, MISMATCH=0, BUSY=0. CMD_READY is 1 after the reset edge.
  - Reset mid-command aborts the command with no further J/K activity.
- Push: on an edge with CMD_VALID && CMD_READY, {OP,MASK,REPEAT} is written at the tail.
  - When full, CMD_READY=0 even if a pop occurs in the same cycle; there is no full bypass.
- FSM states: IDLE, ISSUE, CHECK.
- IDLE:
  - If FIFO non-empty at an edge: pop the head, then J<=MASK&{WIDTH{OP[1]}}, K<=MASK&{WIDTH{OP[0]}}, cnt<=REPEAT, go to ISSUE.
  - A command pushed at edge e is popped no earlier than edge e+1; there is no same-cycle push-to-pop bypass.
- ISSUE, at each edge:
  - Update EXPECTED per bit with the JK rule using the current J/K: 01 clears to 0, 10 sets to 1, 11 inverts, 00 holds. This matches the flop's update at the same edge.
  - If cnt==0: J<=0, K<=0, go to CHECK. Otherwise cnt<=cnt-1.
  - Result: J/K are non-zero for exactly REPEAT+1 cycles.
- CHECK (one cycle):
  - Compare Q_IN with EXPECTED over all WIDTH bits. If they differ, set MISMATCH at the edge.
  - Go to IDLE.
- MISMATCH is cleared only by RESET.
- Throughput: one command per REPEAT+3 cycles (IDLE + ISSUE×(REPEAT+1) + CHECK).
- OP=00 still runs the full ISSUE/CHECK sequence with J=K=0, which acts as a timed check-only command.
- FIFO pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and lower bits are equal; empty = pointers equal.
- Outputs J, K, EXPECTED, MISMATCH, CMD_READY and BUSY are all driven from registers or register-only logic, with no combinational path from Q_IN or CMD_VALID.
- EXPECTED assumes the flop bank is reset by the same RESET. An external async reset of the flops outside RESET is a modelling error and is reported via MISMATCH.

Test Plan:
- Reset sequence: RESET high for 2 cycles -> J=K=0, EXPECTED=0, MISMATCH=0, BUSY=0, CMD_READY=1.
- Set, single cycle: push OP=10, MASK=1111, REPEAT=0 with jkff bank attached.
  - J=1111, K=0000 for exactly 1 cycle, starting 1 cycle after the push edge.
  - Q=1111 and EXPECTED=1111 at CHECK; MISMATCH stays 0.
- Toggle, repeated: from Q=0000, push OP=11, MASK=0101, REPEAT=2.
  - 3 toggle cycles -> Q=EXPECTED=0101.
  - Follow with OP=01, MASK=0100, REPEAT=0 -> Q=0001.
- FIFO backpressure: hold CMD_VALID high with 6 back-to-back commands while the first has REPEAT=15.
  - CMD_READY falls after the FIFO holds DEPTH entries.
  - All 6 commands execute in order; every command after the first starts 18 cycles after the previous one started.
  - BUSY drops only after the last CHECK.
- Mismatch detection: force Q_IN[2]=1 while EXPECTED=0000 during the CHECK of an OP=00 command.
  - MISMATCH rises at the CHECK edge and stays 1 through 3 further correct commands.
- Reset mid-ISSUE: RESET asserted during cycle 2 of a REPEAT=7 toggle.
  - At the next edge: J=K=0, EXPECTED=0, FIFO empty, state IDLE.
  - No further J/K pulses appear.
